// File: rtl/axi_lite_cmd_master.sv
// axi_lite_cmd_master
//   Executes one command at a time from a valid/ready command stream and
//   reports each outcome on a valid/ready response stream.
//   Operations: WRITE (AXI4-Lite write), READ (AXI4-Lite read with an optional
//   masked compare), WAIT_BUSY (wait for a falling edge on busy, with an
//   optional timeout) and WAIT_CYC (idle for a fixed number of cycles).
// Ports
//   M_AXI_ACLK / M_AXI_ARESETN : clock, asynchronous active-low reset
//   cmd_*                      : command stream (op, addr, data, mask, compare)
//   rsp_*                      : response stream (data, resp, mismatch, timeout)
//   busy                       : external core busy flag watched by WAIT_BUSY
//   err_count                  : saturating count of failed responses
//   idle                       : high while no command is in flight
//   M_AXI_*                    : AXI4-Lite master port
module axi_lite_cmd_master #(
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 30,
    parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT_WIDTH      = 16
) (
    input  logic                              M_AXI_ACLK,
    input  logic                              M_AXI_ARESETN,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic [1:0]                        cmd_op,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_data,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_mask,
    input  logic                              cmd_compare,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_data,
    output logic [1:0]                        rsp_resp,
    output logic                              rsp_mismatch,
    output logic                              rsp_timeout,
    input  logic                              busy,
    output logic [15:0]                       err_count,
    output logic                              idle,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                        M_AXI_AWPROT,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                        M_AXI_ARPROT,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY
);

    typedef enum logic [2:0] {
        IDLE, WR, WB, RA, RD, WBUSY, WCYC, RSP
    } state_t;

    localparam logic [TIMEOUT_WIDTH-1:0] CNT_ONE = {{(TIMEOUT_WIDTH-1){1'b0}}, 1'b1};

    state_t                          state_q, state_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [C_M_AXI_DATA_WIDTH-1:0]   data_q, data_d;
    logic [C_M_AXI_DATA_WIDTH-1:0]   mask_q, mask_d;
    logic                            compare_q, compare_d;
    logic                            aw_done_q, aw_done_d;
    logic                            w_done_q, w_done_d;
    logic [TIMEOUT_WIDTH-1:0]        cnt_q, cnt_d;
    logic                            busy_q, busy_d;
    logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic [1:0]                      rsp_resp_q, rsp_resp_d;
    logic                            rsp_mismatch_q, rsp_mismatch_d;
    logic                            rsp_timeout_q, rsp_timeout_d;
    logic [15:0]                     err_count_q, err_count_d;
    logic [TIMEOUT_WIDTH-1:0]        limit;

    assign limit = data_q[TIMEOUT_WIDTH-1:0];

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        data_d         = data_q;
        mask_d         = mask_q;
        compare_d      = compare_q;
        aw_done_d      = aw_done_q;
        w_done_d       = w_done_q;
        cnt_d          = cnt_q;
        busy_d         = busy;
        rsp_data_d     = rsp_data_q;
        rsp_resp_d     = rsp_resp_q;
        rsp_mismatch_d = rsp_mismatch_q;
        rsp_timeout_d  = rsp_timeout_q;
        err_count_d    = err_count_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    addr_d         = cmd_addr;
                    data_d         = cmd_data;
                    mask_d         = cmd_mask;
                    compare_d      = cmd_compare;
                    aw_done_d      = 1'b0;
                    w_done_d       = 1'b0;
                    cnt_d          = '0;
                    rsp_data_d     = '0;
                    rsp_resp_d     = '0;
                    rsp_mismatch_d = 1'b0;
                    rsp_timeout_d  = 1'b0;
                    case (cmd_op)
                        2'b00:   state_d = WR;
                        2'b01:   state_d = RA;
                        2'b10:   state_d = WBUSY;
                        default: state_d = WCYC;
                    endcase
                end
            end
            WR: begin
                // AW and W complete independently; leave once both are done.
                if (M_AXI_AWREADY) aw_done_d = 1'b1;
                if (M_AXI_WREADY)  w_done_d  = 1'b1;
                if ((aw_done_q || M_AXI_AWREADY) && (w_done_q || M_AXI_WREADY))
                    state_d = WB;
            end
            WB: begin
                if (M_AXI_BVALID) begin
                    rsp_resp_d = M_AXI_BRESP;
                    state_d    = RSP;
                end
            end
            RA: begin
                if (M_AXI_ARREADY) state_d = RD;
            end
            RD: begin
                if (M_AXI_RVALID) begin
                    rsp_data_d     = M_AXI_RDATA;
                    rsp_resp_d     = M_AXI_RRESP;
                    rsp_mismatch_d = compare_q &&
                                     ((M_AXI_RDATA | mask_q) != (data_q | mask_q));
                    state_d        = RSP;
                end
            end
            WBUSY: begin
                // A falling edge wins over a timeout landing in the same cycle;
                // a limit of zero disables the timeout.
                if (busy_q && !busy) begin
                    state_d = RSP;
                end else if ((limit != '0) && (cnt_q == limit - CNT_ONE)) begin
                    rsp_timeout_d = 1'b1;
                    state_d       = RSP;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            WCYC: begin
                if ((limit == '0) || (cnt_q == limit - CNT_ONE)) state_d = RSP;
                else                                             cnt_d   = cnt_q + CNT_ONE;
            end
            RSP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if ((state_q != RSP) && (state_d == RSP) &&
            (rsp_mismatch_d || rsp_timeout_d || rsp_resp_d[1]) &&
            (err_count_q != '1))
            err_count_d = err_count_q + 16'd1;
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state_q        <= IDLE;
            addr_q         <= '0;
            data_q         <= '0;
            mask_q         <= '0;
            compare_q      <= 1'b0;
            aw_done_q      <= 1'b0;
            w_done_q       <= 1'b0;
            cnt_q          <= '0;
            busy_q         <= 1'b0;
            rsp_data_q     <= '0;
            rsp_resp_q     <= '0;
            rsp_mismatch_q <= 1'b0;
            rsp_timeout_q  <= 1'b0;
            err_count_q    <= '0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            data_q         <= data_d;
            mask_q         <= mask_d;
            compare_q      <= compare_d;
            aw_done_q      <= aw_done_d;
            w_done_q       <= w_done_d;
            cnt_q          <= cnt_d;
            busy_q         <= busy_d;
            rsp_data_q     <= rsp_data_d;
            rsp_resp_q     <= rsp_resp_d;
            rsp_mismatch_q <= rsp_mismatch_d;
            rsp_timeout_q  <= rsp_timeout_d;
            err_count_q    <= err_count_d;
        end
    end

    // cmd_ready is gated by reset so nothing is offered acceptance while held in reset.
    assign cmd_ready     = (state_q == IDLE) && M_AXI_ARESETN;
    assign idle          = (state_q == IDLE);
    assign rsp_valid     = (state_q == RSP);
    assign rsp_data      = rsp_data_q;
    assign rsp_resp      = rsp_resp_q;
    assign rsp_mismatch  = rsp_mismatch_q;
    assign rsp_timeout   = rsp_timeout_q;
    assign err_count     = err_count_q;

    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = (state_q == WR) && !aw_done_q;
    assign M_AXI_WDATA   = data_q;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WVALID  = (state_q == WR) && !w_done_q;
    assign M_AXI_BREADY  = (state_q == WB);
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = (state_q == RA);
    assign M_AXI_RREADY  = (state_q == RD);

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// tb_axi_lite_cmd_master
//   Directed bench for axi_lite_cmd_master with a small AXI4-Lite memory slave
//   whose ready latencies and response codes are set per scenario.
module tb_axi_lite_cmd_master;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [29:0] cmd_addr;
    logic [31:0] cmd_data;
    logic [31:0] cmd_mask;
    logic        cmd_compare;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_resp;
    logic        rsp_mismatch;
    logic        rsp_timeout;
    logic        busy;
    logic [15:0] err_count;
    logic        idle;
    logic [29:0] M_AXI_AWADDR;
    logic [2:0]  M_AXI_AWPROT;
    logic        M_AXI_AWVALID;
    logic        awready;
    logic [31:0] M_AXI_WDATA;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_WVALID;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        M_AXI_BREADY;
    logic [29:0] M_AXI_ARADDR;
    logic [2:0]  M_AXI_ARPROT;
    logic        M_AXI_ARVALID;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        M_AXI_RREADY;

    axi_lite_cmd_master #(
        .C_M_AXI_ADDR_WIDTH(30),
        .C_M_AXI_DATA_WIDTH(32),
        .TIMEOUT_WIDTH(16)
    ) dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_mask(cmd_mask),
        .cmd_compare(cmd_compare),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_resp(rsp_resp), .rsp_mismatch(rsp_mismatch), .rsp_timeout(rsp_timeout),
        .busy(busy), .err_count(err_count), .idle(idle),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
        .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
        .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid),
        .M_AXI_RREADY(M_AXI_RREADY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int exp_err = 0;

    // ---------------- slave model ----------------
    logic [31:0] mem [0:1023];
    int          aw_lat = 0, w_lat = 0, ar_lat = 0;
    logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
    bit          b_hold = 0;
    int          n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0;
    logic [29:0] wr_addr, rd_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;

    initial begin : slave
        int aw_wait, w_wait, ar_wait;
        bit aw_pend, w_pend, b_pend, ar_pend, r_pend, aw_seen, w_seen;
        bit prev_awv, prev_wv, prev_arv;
        logic [29:0] prev_awaddr, prev_araddr;
        logic [31:0] prev_wdata;
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        arready = 0; rvalid = 0; rdata = 0; rresp = 0;
        wr_addr = 0; rd_addr = 0; wr_data = 0; wr_strb = 0;
        aw_wait = 0; w_wait = 0; ar_wait = 0;
        aw_pend = 0; w_pend = 0; b_pend = 0; ar_pend = 0; r_pend = 0;
        aw_seen = 0; w_seen = 0; prev_awv = 0; prev_wv = 0; prev_arv = 0;
        prev_awaddr = 0; prev_araddr = 0; prev_wdata = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'hA500_0000 | 32'(i);
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
                aw_wait = 0; w_wait = 0; ar_wait = 0;
                aw_pend = 0; w_pend = 0; b_pend = 0; ar_pend = 0; r_pend = 0;
                aw_seen = 0; w_seen = 0; prev_awv = 0; prev_wv = 0; prev_arv = 0;
                continue;
            end
            // a VALID without a handshake must hold with the same payload
            if (prev_awv && !aw_pend) begin
                total++;
                if (M_AXI_AWVALID !== 1'b1 || M_AXI_AWADDR !== prev_awaddr) begin
                    bad++;
                    $display("FAIL aw_stable: awvalid=%b awaddr=%h required 1/%h", M_AXI_AWVALID, M_AXI_AWADDR, prev_awaddr);
                end
            end
            if (prev_wv && !w_pend) begin
                total++;
                if (M_AXI_WVALID !== 1'b1 || M_AXI_WDATA !== prev_wdata) begin
                    bad++;
                    $display("FAIL w_stable: wvalid=%b wdata=%h required 1/%h", M_AXI_WVALID, M_AXI_WDATA, prev_wdata);
                end
            end
            if (prev_arv && !ar_pend) begin
                total++;
                if (M_AXI_ARVALID !== 1'b1 || M_AXI_ARADDR !== prev_araddr) begin
                    bad++;
                    $display("FAIL ar_stable: arvalid=%b araddr=%h required 1/%h", M_AXI_ARVALID, M_AXI_ARADDR, prev_araddr);
                end
            end
            // retire handshakes that completed on the preceding rising edge
            if (aw_pend) begin awready = 0; aw_wait = 0; aw_seen = 1; n_aw++; end
            if (w_pend)  begin wready = 0;  w_wait = 0;  w_seen = 1;  n_w++;  end
            if (b_pend)  begin bvalid = 0; n_b++; end
            if (aw_seen && w_seen) begin
                mem[wr_addr[11:2]] = wr_data;
                aw_seen = 0; w_seen = 0;
                if (!b_hold) begin bvalid = 1; bresp = cfg_bresp; end
            end
            if (r_pend) begin rvalid = 0; n_r++; end
            if (ar_pend) begin
                arready = 0; ar_wait = 0; n_ar++;
                rvalid = 1; rdata = mem[rd_addr[11:2]]; rresp = cfg_rresp;
            end
            if (M_AXI_AWVALID && !awready) begin
                if (aw_wait >= aw_lat) awready = 1; else aw_wait++;
            end
            if (M_AXI_WVALID && !wready) begin
                if (w_wait >= w_lat) wready = 1; else w_wait++;
            end
            if (M_AXI_ARVALID && !arready) begin
                if (ar_wait >= ar_lat) arready = 1; else ar_wait++;
            end
            aw_pend = awready && M_AXI_AWVALID;
            if (aw_pend) wr_addr = M_AXI_AWADDR;
            w_pend = wready && M_AXI_WVALID;
            if (w_pend) begin wr_data = M_AXI_WDATA; wr_strb = M_AXI_WSTRB; end
            b_pend  = bvalid && M_AXI_BREADY;
            ar_pend = arready && M_AXI_ARVALID;
            if (ar_pend) rd_addr = M_AXI_ARADDR;
            r_pend  = rvalid && M_AXI_RREADY;
            prev_awv = M_AXI_AWVALID; prev_awaddr = M_AXI_AWADDR;
            prev_wv  = M_AXI_WVALID;  prev_wdata  = M_AXI_WDATA;
            prev_arv = M_AXI_ARVALID; prev_araddr = M_AXI_ARADDR;
        end
    end

    initial begin : watchdog
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- drivers (called at a falling edge) ----------------
    task automatic send_cmd(input logic [1:0] op, input logic [29:0] addr,
                            input logic [31:0] data, input logic [31:0] mask,
                            input logic cmp, output bit ok);
        ok = 0;
        cmd_op = op; cmd_addr = addr; cmd_data = data; cmd_mask = mask; cmd_compare = cmp;
        cmd_valid = 1;
        for (int i = 0; i < 200; i++) begin
            if (cmd_ready) begin ok = 1; break; end
            @(negedge clk);
        end
        @(negedge clk);
        cmd_valid = 0;
    endtask

    task automatic wait_rsp(output bit ok, output int lat, output logic [31:0] d,
                            output logic [1:0] r, output logic m, output logic t);
        ok = 0; lat = 0; d = '0; r = '0; m = 0; t = 0;
        rsp_ready = 1;
        for (int i = 1; i <= 300; i++) begin
            if (rsp_valid) begin
                ok = 1; lat = i; d = rsp_data; r = rsp_resp; m = rsp_mismatch; t = rsp_timeout;
                break;
            end
            @(negedge clk);
        end
        if (ok) @(negedge clk);
        rsp_ready = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        repeat (3) @(negedge clk);
        total++;
        if ({cmd_ready, idle, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID,
             M_AXI_RREADY, rsp_valid, rsp_mismatch, rsp_timeout} !== 10'b01_0000_0000) begin
            bad++;
            $display("FAIL reset_ctrl: got %b required 0100000000",
                     {cmd_ready, idle, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID,
                      M_AXI_RREADY, rsp_valid, rsp_mismatch, rsp_timeout});
        end
        total++;
        if (rsp_data !== 32'h0 || rsp_resp !== 2'b00 || err_count !== 16'h0) begin
            bad++;
            $display("FAIL reset_rsp: data=%h resp=%b err=%h required 0/00/0", rsp_data, rsp_resp, err_count);
        end
        @(posedge clk); #2 rst_n = 1;
        #1;
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++; $display("FAIL reset_release_ready: cmd_ready=%b required 1", cmd_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_write;
        bit ok; int lat; logic [31:0] d; logic [1:0] r; logic m, t;
        logic [3:0] av, wv;
        aw_lat = 1; w_lat = 2;
        av = '0; wv = '0;
        send_cmd(2'b00, 30'h0100_0004, 32'h80, 32'h0, 1'b0, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL write_accept: not accepted within budget"); end
        for (int k = 0; k < 4; k++) begin
            av = {av[2:0], M_AXI_AWVALID};
            wv = {wv[2:0], M_AXI_WVALID};
            @(negedge clk);
        end
        total++;
        if (av !== 4'b1100 || wv !== 4'b1110) begin
            bad++; $display("FAIL write_valid_drop: aw=%b w=%b required 1100/1110", av, wv);
        end
        wait_rsp(ok, lat, d, r, m, t);
        total++;
        if (!ok || lat != 1 || r !== 2'b00 || d !== 32'h0 || m !== 1'b0 || t !== 1'b0) begin
            bad++; $display("FAIL write_rsp: ok=%0d lat=%0d resp=%b data=%h mm=%b to=%b required 1/1/00/0/0/0", ok, lat, r, d, m, t);
        end
        total++;
        if (wr_addr !== 30'h0100_0004 || wr_strb !== 4'hF || mem[1] !== 32'h80) begin
            bad++; $display("FAIL write_bus: addr=%h strb=%h mem=%h required 01000004/f/80", wr_addr, wr_strb, mem[1]);
        end
        total++;
        if (err_count !== 16'(exp_err)) begin
            bad++; $display("FAIL write_err: err_count=%0d required %0d", err_count, exp_err);
        end
        aw_lat = 0; w_lat = 0;
    endtask

    task automatic test_read_compare;
        bit ok; int lat; logic [31:0] d; logic [1:0] r; logic m, t;
        mem[512] = 32'hDEAD_BEEF;
        send_cmd(2'b01, 30'h800, 32'hDEAD_BEEE, 32'h3, 1'b1, ok);
        wait_rsp(ok, lat, d, r, m, t);
        total++;
        if (!ok || lat != 3 || d !== 32'hDEAD_BEEF || m !== 1'b0 || r !== 2'b00) begin
            bad++; $display("FAIL read_match: ok=%0d lat=%0d data=%h mm=%b resp=%b required 1/3/deadbeef/0/00", ok, lat, d, m, r);
        end
        total++;
        if (err_count !== 16'(exp_err)) begin
            bad++; $display("FAIL read_match_err: err_count=%0d required %0d", err_count, exp_err);
        end
        mem[512] = 32'hDEAD_BEE0;
        send_cmd(2'b01, 30'h800, 32'hDEAD_BEEE, 32'h3, 1'b1, ok);
        wait_rsp(ok, lat, d, r, m, t);
        exp_err++;
        total++;
        if (!ok || d !== 32'hDEAD_BEE0 || m !== 1'b1) begin
            bad++; $display("FAIL read_mismatch: ok=%0d data=%h mm=%b required 1/deadbee0/1", ok, d, m);
        end
        total++;
        if (err_count !== 16'(exp_err)) begin
            bad++; $display("FAIL read_mismatch_err: err_count=%0d required %0d", err_count, exp_err);
        end
        send_cmd(2'b01, 30'h800, 32'hDEAD_BEEE, 32'h3, 1'b0, ok);
        wait_rsp(ok, lat, d, r, m, t);
        total++;
        if (!ok || m !== 1'b0 || err_count !== 16'(exp_err)) begin
            bad++; $display("FAIL read_nocompare: ok=%0d mm=%b err=%0d required 1/0/%0d", ok, m, err_count, exp_err);
        end
    endtask

    task automatic test_wait_cyc;
        bit ok; int lat; logic [31:0] d; logic [1:0] r; logic m, t;
        send_cmd(2'b11, 30'h0, 32'd3, 32'h0, 1'b0, ok);
        wait_rsp(ok, lat, d, r, m, t);
        total++;
        if (!ok || lat != 4 || d !== 32'h0 || t !== 1'b0 || r !== 2'b00) begin
            bad++; $display("FAIL wait_cyc3: ok=%0d lat=%0d data=%h to=%b required 1/4/0/0", ok, lat, d, t);
        end
        send_cmd(2'b11, 30'h0, 32'd0, 32'h0, 1'b0, ok);
        wait_rsp(ok, lat, d, r, m, t);
        total++;
        if (!ok || lat != 2) begin
            bad++; $display("FAIL wait_cyc0: ok=%0d lat=%0d required 1/2", ok, lat);
        end
    endtask

    task automatic test_wait_busy;
        bit ok; int lat; logic [31:0] d; logic [1:0] r; logic m, t;
        int seen;
        busy = 1;
        send_cmd(2'b10, 30'h0, 32'd50, 32'h0, 1'b0, ok);
        repeat (19) @(negedge clk);
        busy = 0;
        wait_rsp(ok, lat, d, r, m, t);
        total++;
        if (!ok || lat != 2 || t !== 1'b0 || d !== 32'h0) begin
            bad++; $display("FAIL wait_busy_fall: ok=%0d lat=%0d to=%b required 1/2/0", ok, lat, t);
        end
        busy = 1;
        send_cmd(2'b10, 30'h0, 32'd50, 32'h0, 1'b0, ok);
        wait_rsp(ok, lat, d, r, m, t);
        exp_err++;
        total++;
        if (!ok || lat != 51 || t !== 1'b1) begin
            bad++; $display("FAIL wait_busy_timeout: ok=%0d lat=%0d to=%b required 1/51/1", ok, lat, t);
        end
        total++;
        if (err_count !== 16'(exp_err)) begin
            bad++; $display("FAIL wait_busy_err: err_count=%0d required %0d", err_count, exp_err);
        end
        send_cmd(2'b10, 30'h0, 32'd0, 32'h0, 1'b0, ok);
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            if (rsp_valid) seen++;
            @(negedge clk);
        end
        total++;
        if (seen != 0) begin
            bad++; $display("FAIL wait_busy_nolimit: early responses=%0d required 0", seen);
        end
        busy = 0;
        wait_rsp(ok, lat, d, r, m, t);
        total++;
        if (!ok || lat != 2 || t !== 1'b0) begin
            bad++; $display("FAIL wait_busy_nolimit_rsp: ok=%0d lat=%0d to=%b required 1/2/0", ok, lat, t);
        end
    endtask

    task automatic test_rresp_hold;
        bit ok; int w;
        logic [36:0] snap;
        cfg_rresp = 2'b10;
        mem[513] = 32'h1234_5678;
        send_cmd(2'b01, 30'h804, 32'h0, 32'h0, 1'b0, ok);
        w = 0;
        while (!rsp_valid && w < 50) begin @(negedge clk); w++; end
        exp_err++;
        snap = {rsp_valid, rsp_data, rsp_resp, rsp_mismatch, rsp_timeout};
        total++;
        if (snap !== {1'b1, 32'h1234_5678, 2'b10, 1'b0, 1'b0}) begin
            bad++; $display("FAIL rresp_rsp: got %h required %h", snap, {1'b1, 32'h1234_5678, 2'b10, 1'b0, 1'b0});
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            total++;
            if ({rsp_valid, rsp_data, rsp_resp, rsp_mismatch, rsp_timeout} !== snap ||
                err_count !== 16'(exp_err)) begin
                bad++; $display("FAIL rresp_hold%0d: got %h err=%0d required %h err=%0d", k,
                                {rsp_valid, rsp_data, rsp_resp, rsp_mismatch, rsp_timeout}, err_count, snap, exp_err);
            end
        end
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        total++;
        if (rsp_valid !== 1'b0 || idle !== 1'b1 || err_count !== 16'(exp_err)) begin
            bad++; $display("FAIL rresp_release: valid=%b idle=%b err=%0d required 0/1/%0d", rsp_valid, idle, err_count, exp_err);
        end
        cfg_rresp = 2'b00;
    endtask

    task automatic test_reset_in_wb;
        bit ok; int w; int seen;
        b_hold = 1;
        send_cmd(2'b00, 30'h10, 32'h55, 32'h0, 1'b0, ok);
        w = 0;
        while (!M_AXI_BREADY && w < 20) begin @(negedge clk); w++; end
        total++;
        if (M_AXI_BREADY !== 1'b1) begin
            bad++; $display("FAIL rst_wb_reach: bready=%b required 1", M_AXI_BREADY);
        end
        @(posedge clk); #2 rst_n = 0;
        #1;
        total++;
        if ({M_AXI_BREADY, cmd_ready, rsp_valid, idle} !== 4'b0001 || err_count !== 16'h0) begin
            bad++; $display("FAIL rst_wb_in_reset: bready/ready/valid/idle=%b err=%0d required 0001/0",
                            {M_AXI_BREADY, cmd_ready, rsp_valid, idle}, err_count);
        end
        repeat (2) @(posedge clk);
        #3;
        total++;
        if ({M_AXI_BREADY, cmd_ready, M_AXI_AWVALID, M_AXI_WVALID} !== 4'b0000) begin
            bad++; $display("FAIL rst_wb_held: bready/ready/awv/wv=%b required 0000",
                            {M_AXI_BREADY, cmd_ready, M_AXI_AWVALID, M_AXI_WVALID});
        end
        @(posedge clk); #2 rst_n = 1;
        #1;
        total++;
        if (cmd_ready !== 1'b1 || idle !== 1'b1) begin
            bad++; $display("FAIL rst_wb_release: cmd_ready=%b idle=%b required 1/1", cmd_ready, idle);
        end
        b_hold = 0;
        exp_err = 0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++; $display("FAIL rst_wb_no_rsp: responses=%0d required 0", seen);
        end
    endtask

    task automatic test_back_to_back;
        bit ok; int lat; logic [31:0] d; logic [1:0] r; logic m, t;
        int rsp_cnt;
        int a0, w0, b0, ar0, r0;
        logic [29:0] addr;
        logic [31:0] exp_d;
        rsp_cnt = 0;
        a0 = n_aw; w0 = n_w; b0 = n_b; ar0 = n_ar; r0 = n_r;
        for (int i = 0; i < 7; i++) begin
            send_cmd(2'b00, 30'(4 * i), 32'hC0F1_0000 + 32'(i), 32'h0, 1'b0, ok);
            wait_rsp(ok, lat, d, r, m, t);
            if (ok) rsp_cnt++;
            total++;
            if (!ok || r !== 2'b00 || d !== 32'h0) begin
                bad++; $display("FAIL b2b_cfg%0d: ok=%0d resp=%b data=%h required 1/00/0", i, ok, r, d);
            end
        end
        for (int i = 0; i < 500; i++) begin
            send_cmd(2'b00, 30'h40 + 30'(4 * i), 32'h1000_0000 + 32'(3 * i), 32'h0, 1'b0, ok);
            wait_rsp(ok, lat, d, r, m, t);
            if (ok) rsp_cnt++;
            total++;
            if (!ok || r !== 2'b00) begin
                bad++; $display("FAIL b2b_in%0d: ok=%0d resp=%b required 1/00", i, ok, r);
            end
        end
        busy = 1;
        send_cmd(2'b10, 30'h0, 32'd0, 32'h0, 1'b0, ok);
        repeat (10) @(negedge clk);
        busy = 0;
        wait_rsp(ok, lat, d, r, m, t);
        if (ok) rsp_cnt++;
        total++;
        if (!ok || t !== 1'b0) begin
            bad++; $display("FAIL b2b_wait: ok=%0d to=%b required 1/0", ok, t);
        end
        for (int j = 0; j < 505; j++) begin
            if (j < 7) begin
                addr  = 30'(4 * j);
                exp_d = 32'hC0F1_0000 + 32'(j);
            end else begin
                addr  = 30'h40 + 30'(4 * (j - 7));
                exp_d = 32'h1000_0000 + 32'(3 * (j - 7));
            end
            send_cmd(2'b01, addr, exp_d, 32'h0, 1'b1, ok);
            wait_rsp(ok, lat, d, r, m, t);
            if (ok) rsp_cnt++;
            total++;
            if (!ok || d !== exp_d || m !== 1'b0 || r !== 2'b00) begin
                bad++; $display("FAIL b2b_rd%0d: ok=%0d data=%h mm=%b required 1/%h/0", j, ok, d, m, exp_d);
            end
        end
        total++;
        if (rsp_cnt != 1013) begin
            bad++; $display("FAIL b2b_count: responses=%0d required 1013", rsp_cnt);
        end
        total++;
        if (n_aw - a0 != 507 || n_w - w0 != 507 || n_b - b0 != 507 ||
            n_ar - ar0 != 505 || n_r - r0 != 505) begin
            bad++; $display("FAIL b2b_handshakes: aw=%0d w=%0d b=%0d ar=%0d r=%0d required 507/507/507/505/505",
                            n_aw - a0, n_w - w0, n_b - b0, n_ar - ar0, n_r - r0);
        end
        total++;
        if (err_count !== 16'(exp_err)) begin
            bad++; $display("FAIL b2b_err: err_count=%0d required %0d", err_count, exp_err);
        end
    endtask

    initial begin
        rst_n = 0; busy = 0; cmd_valid = 0; rsp_ready = 0;
        cmd_op = 0; cmd_addr = 0; cmd_data = 0; cmd_mask = 0; cmd_compare = 0;
        test_reset;
        test_write;
        test_read_compare;
        test_wait_cyc;
        test_wait_busy;
        test_rresp_hold;
        test_reset_in_wb;
        test_back_to_back;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
